// File: rtl/pot_pkg.sv
// Shared types and width helpers for the potentiometer sampler.
package pot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_UPDATE
  } state_e;

  // Counter/select width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pot_deadband.sv
// Write/pulse decision for one channel update: first-update override plus
// either a strict-change rule or, with POT_HYST_EN defined, a HYST-LSB deadband.
module pot_deadband
  import pot_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int HYST   = 2
) (
  input  logic [DATA_W-1:0] avg_i,
  input  logic [DATA_W-1:0] cur_i,
  input  logic              first_i,
  output logic              upd_o
);

  localparam logic [DATA_W:0] HYST_V = (DATA_W + 1)'(HYST);

  logic [DATA_W-1:0] diff;

  always_comb begin
    diff = (avg_i >= cur_i) ? (avg_i - cur_i) : (cur_i - avg_i);
  end

`ifdef POT_HYST_EN
  assign upd_o = first_i || ({1'b0, diff} > HYST_V);
`else
  logic unused_hyst;
  assign unused_hyst = ^HYST_V;
  assign upd_o       = first_i || (diff != '0);
`endif

endmodule

// File: rtl/pot_sampler.sv
// Multi-channel pot sampler: settle, boxcar average, per-channel deadband update.
// Optional feature macro: POT_HYST_EN (deadband rule inside pot_deadband).
module pot_sampler
  import pot_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int NUM_CH        = 2,
  parameter int SETTLE_CYCLES = 1000,
  parameter int AVG_LOG2      = 3,
  parameter int HYST          = 2
) (
  input  logic                       sys_clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [DATA_W-1:0]          adc_data,
  output logic [cnt_w(NUM_CH)-1:0]   ch_sel,
  output logic [NUM_CH*DATA_W-1:0]   value,
  output logic [NUM_CH-1:0]          value_valid
);

  localparam int CW = cnt_w(NUM_CH);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam int MW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int AW = DATA_W + AVG_LOG2;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] SAMPLE_LAST = MW'((1 << AVG_LOG2) - 1);
  localparam logic [CW-1:0] CH_LAST     = CW'(NUM_CH - 1);

  // Truncating boxcar mean; the accumulator is wide enough to never wrap.
  function automatic logic [DATA_W-1:0] box_avg(input logic [AW-1:0] sum);
    return DATA_W'(sum >> AVG_LOG2);
  endfunction

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   adc_q, adc_d;
  logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
  logic [MW-1:0]       sample_cnt_q, sample_cnt_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       ch_q, ch_d;
  logic [DATA_W-1:0]   value_q [NUM_CH];
  logic [DATA_W-1:0]   value_d [NUM_CH];
  logic [NUM_CH-1:0]   first_q, first_d;
  logic [NUM_CH-1:0]   vld_q, vld_d;
  logic [DATA_W-1:0]   avg;
  logic                upd;

  assign avg = box_avg(acc_q);

  pot_deadband #(
    .DATA_W (DATA_W),
    .HYST   (HYST)
  ) u_deadband (
    .avg_i   (avg),
    .cur_i   (value_q[ch_q]),
    .first_i (first_q[ch_q]),
    .upd_o   (upd)
  );

  always_comb begin
    state_d      = state_q;
    adc_d        = adc_data;
    settle_cnt_d = settle_cnt_q;
    sample_cnt_d = sample_cnt_q;
    acc_d        = acc_q;
    ch_d         = ch_q;
    value_d      = value_q;
    first_d      = first_q;
    vld_d        = '0;
    // Dropping enable parks in IDLE but keeps channel, values and first-flags.
    if (!enable) begin
      state_d      = ST_IDLE;
      settle_cnt_d = '0;
      sample_cnt_d = '0;
      acc_d        = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d      = ST_SAMPLE;
            settle_cnt_d = '0;
            sample_cnt_d = '0;
            acc_d        = '0;
          end else begin
            settle_cnt_d = settle_cnt_q + 1'b1;
          end
        end
        ST_SAMPLE: begin
          acc_d = acc_q + AW'(adc_q);
          if (sample_cnt_q == SAMPLE_LAST) begin
            state_d      = ST_UPDATE;
            sample_cnt_d = '0;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
        ST_UPDATE: begin
          if (upd) begin
            value_d[ch_q] = avg;
            vld_d[ch_q]   = 1'b1;
          end
          first_d[ch_q] = 1'b0;
          ch_d          = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
          state_d       = ST_SETTLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      adc_q        <= '0;
      settle_cnt_q <= '0;
      sample_cnt_q <= '0;
      acc_q        <= '0;
      ch_q         <= '0;
      value_q      <= '{default: '0};
      first_q      <= '1;
      vld_q        <= '0;
    end else begin
      state_q      <= state_d;
      adc_q        <= adc_d;
      settle_cnt_q <= settle_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      acc_q        <= acc_d;
      ch_q         <= ch_d;
      value_q      <= value_d;
      first_q      <= first_d;
      vld_q        <= vld_d;
    end
  end

  assign ch_sel      = ch_q;
  assign value_valid = vld_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_flat
    assign value[k*DATA_W +: DATA_W] = value_q[k];
  end

endmodule

// File: doc/pot_sampler.md
# pot_sampler

Multi-channel potentiometer sampler that reads a parallel ADC bus on the JA/JB-style J ports, steps an external analog mux through `NUM_CH` channels, and produces one filtered value per channel. Each channel gets a settle delay, a boxcar average of 2^`AVG_LOG2` samples, and an optional deadband that suppresses jitter. It feeds paddle-position logic in the pong datapath.

## Interface
- `DATA_W`, 8: ADC sample width.
- `NUM_CH`, 2: channels scanned (≥1).
- `SETTLE_CYCLES`, 1000: cycles after mux change before sampling (≥1).
- `AVG_LOG2`, 3: log2 of samples averaged per update (0 allowed).
- `HYST`, 2: deadband magnitude, in LSBs.
- `sys_clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  scan enable.
- `adc_data`  in  `DATA_W`  ADC parallel output (from JPorts).
- `ch_sel`  out  clog2(`NUM_CH`), min 1  external mux select.
- `value`  out  `NUM_CH*DATA_W`  filtered values; channel k at [k*DATA_W +: DATA_W].
- `value_valid`  out  `NUM_CH`  one-cycle pulse per channel when its value changes.

## Operation
- `adc_data` is registered once on input; all sampling uses the registered copy.
- FSM states:
  - IDLE → SETTLE when `enable`=1.
  - SETTLE: counts `SETTLE_CYCLES` cycles, then goes to SAMPLE.
  - SAMPLE: accumulates the registered sample for 2^`AVG_LOG2` cycles, then goes to UPDATE.
  - UPDATE: lasts one cycle, then goes to SETTLE with `ch_sel` advanced.
- Accumulator width is `DATA_W+AVG_LOG2`, so it never overflows. It clears on entry to SAMPLE. avg = acc >> `AVG_LOG2` (truncating).
- UPDATE writes avg to `value[ch]` and pulses `value_valid[ch]` when:
  - the channel has had no update since reset (first-flag set; the flag then clears), or
  - the update condition below holds.
- Update condition: with hysteresis compiled in, |avg − value[ch]| > `HYST`; without it, avg ≠ value[ch].
- `ch_sel` wraps from `NUM_CH`−1 to 0. When `NUM_CH`=1 it stays 0.
- `enable`=0 in any state: next state is IDLE. Counters and accumulator are discarded; `ch_sel`, `value` and first-flags are held. Re-enable restarts SETTLE on the same channel.
- Reset mid-operation: all state returns to its reset value at the next edge. No `value_valid` pulse is issued.

## Timing
- Reset values:
  - state IDLE.
  - `ch_sel`=0.
  - `value`=0.
  - `value_valid`=0.
  - counters and accumulator 0.
  - all first-flags set.
- Per-channel period (enabled): `SETTLE_CYCLES` + 2^`AVG_LOG2` + 1 cycles. Full scan is `NUM_CH` × that.
- `value` and `value_valid` are registered and change on the edge that ends UPDATE. `value_valid` is high for exactly one cycle. At most one bit of `value_valid` is set at a time.
- `ch_sel` changes on the same edge that ends UPDATE. The settle window starts the following cycle.
- Input-register latency: 1 cycle. A sample presented at the ADC is accumulated in the cycle after it is registered.

## Configuration
- `POT_HYST_EN` defined: deadband update rule with `HYST` applies after the first update.
- `POT_HYST_EN` not defined: any change in avg updates the output; `HYST` is ignored.

## Structure
- Package `pot_pkg` holds:
  - the state enum (IDLE, SETTLE, SAMPLE, UPDATE);
  - a clog2-based width helper for `ch_sel` and the settle counter.
- Sub-module `pot_deadband`: combinational compare of avg vs. current value (with first-flag). Outputs the write/pulse decision; contains the `POT_HYST_EN` logic.
- Top level holds the FSM, counters, accumulator, value registers and first-flags.

## Test plan
Bench parameters: `DATA_W`=8, `NUM_CH`=2, `SETTLE_CYCLES`=4, `AVG_LOG2`=2, `HYST`=2, `POT_HYST_EN` defined.
- Hold 0x80 while `ch_sel`=0 and 0x40 while `ch_sel`=1, after reset → `value[7:0]`=0x80 with `value_valid`=01 at cycle 9 after enable; `value[15:8]`=0x40 with `value_valid`=10 nine cycles later; `ch_sel` wraps back to 0.
- Channel 0 samples 10, 11, 12, 13 on the first pass → `value[7:0]`=11 (sum 46 >> 2).
- Channel 0 at 0x80, next pass avg 0x81 → no update, no pulse. Following pass avg 0x83 → `value[7:0]`=0x83 with a pulse.
- All samples 0xFF → `value`=0xFF with no wrap (accumulator holds 0x3FC).
- Drop `enable` mid-SAMPLE for 3 cycles → no pulse, `ch_sel` unchanged; after re-enable, update arrives 9 cycles later. Assert `reset` during SETTLE → all outputs 0 next cycle.
- Rebuild without `POT_HYST_EN` → the avg 0x80→0x81 step updates and pulses.
